// File: rtl/param_tensor_sink.sv
// param_tensor_sink: stores one parameter tensor arriving as a valid/ready
// beat stream into an internal memory, then stalls the stream until released.
// Stored words are read through a ROM-style port with a 2-cycle latency.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_FILL | accepting beats, writing mem[wr_ptr] on each handshake
// S_FULL | complete tensor stored, stream stalled until release_in
module param_tensor_sink #(
    parameter int DATA_PRECISION_0  = 16,
    parameter int TENSOR_SIZE_DIM_0 = 32,
    parameter int PARALLELISM_DIM_0 = 1,
    parameter int PARALLELISM_DIM_1 = 1,
    localparam int LANES      = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
    localparam int IN_DEPTH   = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0,
    localparam int ADDR_WIDTH = $clog2(IN_DEPTH) + 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_PRECISION_0-1:0]         data_in [LANES],
    input  logic                                data_in_valid,
    output logic                                data_in_ready,
    input  logic [ADDR_WIDTH-1:0]               address0,
    input  logic                                ce0,
    output logic [DATA_PRECISION_0*LANES-1:0]   q0,
    output logic                                full,
    input  logic                                release_in,
    output logic [ADDR_WIDTH-1:0]               beat_count
);

    localparam int WORD_W = DATA_PRECISION_0 * LANES;
    // Index width into the memory array; kept at least 1 bit for a 1-deep tensor.
    localparam int IDX_W  = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(IN_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_A  = ADDR_WIDTH'(IN_DEPTH - 1);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  wr_ptr_next;
    logic                   accept;
    logic [WORD_W-1:0]      beat_packed;
    logic [WORD_W-1:0]      mem [IN_DEPTH];
    logic [WORD_W-1:0]      r0;

    // Ready is gated by rst so nothing handshakes while reset is held.
    assign data_in_ready = (state == S_FILL) && !rst;
    assign accept        = data_in_valid && data_in_ready;
    assign full          = (state == S_FULL);
    assign beat_count    = wr_ptr;

    // Pack lanes into one memory word, lane 0 in the least significant slice.
    always_comb begin
        beat_packed = '0;
        for (int j = 0; j < LANES; j++) begin
            beat_packed[DATA_PRECISION_0*j +: DATA_PRECISION_0] = data_in[j];
        end
    end

    // Next-state and write-pointer logic.
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        case (state)
            S_FILL: begin
                if (accept) begin
                    if (wr_ptr == LAST_A) begin
                        wr_ptr_next = '0;
                        state_next  = S_FULL;
                    end else begin
                        wr_ptr_next = wr_ptr + ADDR_WIDTH'(1);
                    end
                end
            end
            S_FULL: begin
                if (release_in) begin
                    state_next = S_FILL;
                end
            end
        endcase
    end

    // State and write-pointer registers; rst wins over accept and release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_FILL;
            wr_ptr <= '0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr_next;
        end
    end

    // Tensor storage; contents survive reset and are simply overwritten by the next fill.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[IDX_W-1:0]] <= beat_packed;
        end
    end

    // Two-stage read pipeline; both stages freeze when ce0 is low.
    // Reading the pre-edge array value gives read-before-write on address collisions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r0 <= '0;
            q0 <= '0;
        end else if (ce0) begin
            r0 <= (address0 < DEPTH_A) ? mem[address0[IDX_W-1:0]] : '0;
            q0 <= r0;
        end
    end

endmodule
